down_rate_divider: RTL and testbench
====================================

DOWN_RATE_DIVIDER -- requirements
Module: down_rate_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetb, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: count enable, one decrement per enabled edge.
REQ-005 The block SHALL have port load, input, 1 bit: load request.
REQ-006 The block SHALL have port load_value, input, WIDTH bits: start and reload value.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = auto-reload, 1 = one-shot; sampled only when load is accepted.
REQ-008 The block SHALL have port Q, output, WIDTH bits: current count, registered.
REQ-009 The block SHALL have port pulse, output, 1 bit: terminal-count strobe, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in state RUN.

Function
REQ-011 The block SHALL use two states: IDLE and RUN.
REQ-012 The block SHALL hold an internal reload register and a latched mode bit, both written only on an accepted load.
REQ-013 In any state, load=1 SHALL set Q<=load_value, reload<=load_value, mode latch<=mode, state<=RUN and pulse<=0; load has priority over enable.
REQ-014 In RUN with enable=1, load=0 and Q!=0, the block SHALL set Q<=Q-1 and pulse<=0 (unsigned decrement, no underflow path).
REQ-015 In RUN with enable=1, load=0 and Q==0, the block SHALL set pulse<=1 for exactly that one cycle.
- If the latched mode is 0, the block SHALL also set Q<=reload and stay in RUN.
- If the latched mode is 1, the block SHALL hold Q at 0 and go to IDLE.
REQ-016 With enable=0 (and load=0), the block SHALL hold Q and state and drive pulse<=0.
REQ-017 In IDLE, enable SHALL be ignored: Q holds and pulse stays 0.
REQ-018 In auto-reload mode the pulse period SHALL be reload+1 enabled cycles; reload=0 gives a pulse on every enabled cycle with Q held at 0.
REQ-019 busy SHALL equal (state==RUN); it falls in the same cycle pulse rises for a one-shot terminal.
REQ-020 A load arriving on the same edge as a terminal count SHALL suppress that pulse; the load takes effect.

Reset
REQ-021 When resetb=0 at a rising clock edge, the block SHALL set Q=0, reload=0, mode latch=0, pulse=0, busy=0 and state=IDLE, regardless of load or enable.
REQ-022 A reset in the middle of a count SHALL abort it with no pulse emitted; operation resumes only after a new load.
REQ-023 Reset SHALL NOT act asynchronously: there is no state change between clock edges.

Structure
REQ-024 A shared package SHALL hold the WIDTH default and the IDLE/RUN state encoding.
REQ-025 The count register SHALL be built as a decrementing T-cell chain, using one sub-module, tff_down_cell, per bit.
- tff_down_cell inputs: toggle, sync load bit, clock, resetb.
- Bit i SHALL toggle when the decrement is active and all lower bits are 0.
REQ-026 The control FSM, reload register and pulse register SHALL reside in the top module.

Verification
REQ-027 Reset, load 3 mode 0, enable held 1 -> Q = 3,2,1,0,3,2,...; pulse high on the cycle Q returns to 3, every 4th enabled edge; busy=1 throughout.
REQ-028 Load 0 mode 0, enable 1 -> Q stays 0, pulse=1 every cycle.
REQ-029 Load 2 mode 1, enable 1 -> Q = 2,1,0; one pulse, busy drops with it; 10 further enabled cycles give no pulse and Q=0.
REQ-030 Load 5 mode 0, enable toggling 1,0,0,1 -> Q holds during enable=0 gaps; pulse only after 6 enabled edges.
REQ-031 Load 7, count to Q=0, then load=1 (value 9) with enable=1 on the terminal edge -> Q=9, no pulse.
REQ-032 Load 200, count to Q=150, then resetb=0 for one edge -> Q=0, busy=0, pulse=0 next cycle; enable alone does not restart the count.

Source files
------------

// File: rtl/down_rate_divider_pkg.sv
// Shared constants for the down-rate divider: default width and control state encoding.
package down_rate_divider_pkg;

  localparam int unsigned DRD_WIDTH_DEFAULT = 8;

  localparam int unsigned STATE_W = 1;
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;

endpackage : down_rate_divider_pkg

// File: rtl/down_rate_divider_tff.sv
// One bit of the decrementing count chain: a toggle flop with a synchronous parallel load.
module tff_down_cell (
  input  logic clock,
  input  logic resetb,
  input  logic toggle_i,
  input  logic load_i,
  input  logic load_bit_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Load wins over toggle so a reload or new start value overrides the decrement.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_bit_i;
    end else if (toggle_i) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : tff_down_cell

// File: rtl/down_rate_divider.sv
// Programmable down-counting rate divider with auto-reload or one-shot terminal pulse.
module down_rate_divider
  import down_rate_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DRD_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             pulse,
  output logic             busy
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   reload_q, reload_d;
  logic               mode_q, mode_d;
  logic               pulse_q, pulse_d;

  logic [WIDTH-1:0]   count;
  logic               count_zero;
  logic               run;
  logic               dec_active;
  logic               terminal;
  logic               cell_load;
  logic [WIDTH-1:0]   cell_load_val;
  logic [WIDTH:0]     lower_zero;
  logic [WIDTH-1:0]   cell_toggle;

  assign run        = (state_q == ST_RUN);
  assign count_zero = (count == '0);
  assign dec_active = run & enable & ~load & ~count_zero;
  assign terminal   = run & enable & ~load & count_zero;

  // Borrow chain: a bit flips on decrement when every lower bit is already zero.
  assign lower_zero[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign lower_zero[i+1] = lower_zero[i] & ~count[i];
    assign cell_toggle[i]  = dec_active & lower_zero[i];

    tff_down_cell u_cell (
      .clock      (clock),
      .resetb     (resetb),
      .toggle_i   (cell_toggle[i]),
      .load_i     (cell_load),
      .load_bit_i (cell_load_val[i]),
      .q_o        (count[i])
    );
  end

  always_comb begin
    state_d       = state_q;
    reload_d      = reload_q;
    mode_d        = mode_q;
    pulse_d       = 1'b0;
    cell_load     = 1'b0;
    cell_load_val = load_value;
    if (load) begin
      cell_load = 1'b1;
      reload_d  = load_value;
      mode_d    = mode;
      state_d   = ST_RUN;
    end else if (terminal) begin
      pulse_d = 1'b1;
      if (!mode_q) begin
        cell_load     = 1'b1;
        cell_load_val = reload_q;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      mode_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      pulse_q  <= pulse_d;
    end
  end

  assign Q     = count;
  assign pulse = pulse_q;
  assign busy  = run;

endmodule : down_rate_divider

// File: tb/tb_down_rate_divider.sv
// Directed self-checking bench for down_rate_divider.
module tb_down_rate_divider;

  localparam int unsigned W = 8;

  logic         clock;
  logic         resetb;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         mode;
  logic [W-1:0] Q;
  logic         pulse;
  logic         busy;

  int vectors;
  int miscompares;

  down_rate_divider #(.WIDTH(W)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .mode       (mode),
    .Q          (Q),
    .pulse      (pulse),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b0; load = 1'b1; enable = 1'b1; load_value = 8'd55; mode = 1'b1;
    step();
    step();
    load = 1'b0; enable = 1'b0;
    vectors++;
    if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: Q=%0d pulse=%b busy=%b, want Q=0 pulse=0 busy=0", Q, pulse, busy);
    end
    resetb = 1'b1;
    step();
    vectors++;
    if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release: Q=%0d pulse=%b busy=%b, want 0/0/0", Q, pulse, busy);
    end
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] eq [8] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic         ep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_value = 8'd3; mode = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    vectors++;
    if ({Q, pulse, busy} !== {8'd3, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL auto_load: Q=%0d pulse=%b busy=%b, want Q=3 pulse=0 busy=1", Q, pulse, busy);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if ({Q, pulse, busy} !== {eq[i], ep[i], 1'b1}) begin
        miscompares++;
        $display("FAIL auto_reload[%0d]: Q=%0d pulse=%b busy=%b, want Q=%0d pulse=%b busy=1",
                 i, Q, pulse, busy, eq[i], ep[i]);
      end
    end
  endtask

  task automatic test_reload_zero();
    load = 1'b1; load_value = 8'd0; mode = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    vectors++;
    if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_load: Q=%0d pulse=%b busy=%b, want Q=0 pulse=0 busy=1", Q, pulse, busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({Q, pulse, busy} !== {8'd0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL zero_reload[%0d]: Q=%0d pulse=%b busy=%b, want Q=0 pulse=1 busy=1",
                 i, Q, pulse, busy);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] eq [3] = '{8'd1, 8'd0, 8'd0};
    logic         ep [3] = '{1'b0, 1'b0, 1'b1};
    logic         eb [3] = '{1'b1, 1'b1, 1'b0};
    load = 1'b1; load_value = 8'd2; mode = 1'b1; enable = 1'b1;
    step();
    load = 1'b0; mode = 1'b0;
    vectors++;
    if ({Q, pulse, busy} !== {8'd2, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL oneshot_load: Q=%0d pulse=%b busy=%b, want Q=2 pulse=0 busy=1", Q, pulse, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({Q, pulse, busy} !== {eq[i], ep[i], eb[i]}) begin
        miscompares++;
        $display("FAIL oneshot[%0d]: Q=%0d pulse=%b busy=%b, want Q=%0d pulse=%b busy=%b",
                 i, Q, pulse, busy, eq[i], ep[i], eb[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL oneshot_idle[%0d]: Q=%0d pulse=%b busy=%b, want 0/0/0", i, Q, pulse, busy);
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic         en [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] eq [12] = '{8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd5};
    logic         ep [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_value = 8'd5; mode = 1'b0; enable = 1'b0;
    step();
    load = 1'b0;
    vectors++;
    if ({Q, pulse, busy} !== {8'd5, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL gaps_load: Q=%0d pulse=%b busy=%b, want Q=5 pulse=0 busy=1", Q, pulse, busy);
    end
    for (int i = 0; i < 12; i++) begin
      enable = en[i];
      step();
      vectors++;
      if ({Q, pulse, busy} !== {eq[i], ep[i], 1'b1}) begin
        miscompares++;
        $display("FAIL gaps[%0d]: Q=%0d pulse=%b busy=%b, want Q=%0d pulse=%b busy=1",
                 i, Q, pulse, busy, eq[i], ep[i]);
      end
    end
  endtask

  task automatic test_load_on_terminal();
    load = 1'b1; load_value = 8'd7; mode = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) step();
    vectors++;
    if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL term_reach: Q=%0d pulse=%b busy=%b, want Q=0 pulse=0 busy=1", Q, pulse, busy);
    end
    load = 1'b1; load_value = 8'd9;
    step();
    load = 1'b0;
    vectors++;
    if ({Q, pulse, busy} !== {8'd9, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL term_load: Q=%0d pulse=%b busy=%b, want Q=9 pulse=0 busy=1", Q, pulse, busy);
    end
    step();
    vectors++;
    if ({Q, pulse, busy} !== {8'd8, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL term_after: Q=%0d pulse=%b busy=%b, want Q=8 pulse=0 busy=1", Q, pulse, busy);
    end
  endtask

  task automatic test_reset_mid_count();
    load = 1'b1; load_value = 8'd200; mode = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 50; i++) step();
    vectors++;
    if ({Q, pulse, busy} !== {8'd150, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_count: Q=%0d pulse=%b busy=%b, want Q=150 pulse=0 busy=1", Q, pulse, busy);
    end
    resetb = 1'b0;
    #2;
    vectors++;
    if ({Q, pulse, busy} !== {8'd150, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_is_sync: Q=%0d pulse=%b busy=%b, want Q=150 pulse=0 busy=1", Q, pulse, busy);
    end
    step();
    resetb = 1'b1;
    vectors++;
    if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: Q=%0d pulse=%b busy=%b, want 0/0/0", Q, pulse, busy);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({Q, pulse, busy} !== {8'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL no_restart[%0d]: Q=%0d pulse=%b busy=%b, want 0/0/0", i, Q, pulse, busy);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetb      = 1'b0;
    enable      = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    mode        = 1'b0;
    test_reset();
    test_auto_reload();
    test_reload_zero();
    test_one_shot();
    test_enable_gaps();
    test_load_on_terminal();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_down_rate_divider
